// File: rtl/vrf_pkg.sv
// Shared types and sizing helpers for the vector register file.
package vrf_pkg;

   typedef enum logic {CLEAR, READY} vrf_state_e;

   function automatic int data_width(input int num_lanes, input int lane_width);
      return num_lanes * lane_width;
   endfunction

   // Width needed to index num_regs entries; never narrower than one bit.
   function automatic int cnt_width(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

endpackage

// File: rtl/vrf_clear_fsm.sv
// Post-reset clear sweep: walks every register once with a zero write, then
// raises ready and stays in READY until the next reset.
module vrf_clear_fsm
   import vrf_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int CNT_W    = cnt_width(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   output logic             ready,
   output logic             clr_en,
   output logic [CNT_W-1:0] clr_addr
);

   vrf_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(NUM_REGS - 1)) begin
            state_d = READY;
            ready_d = 1'b1;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   assign ready    = ready_q;
   assign clr_en   = (state_q == CLEAR);
   assign clr_addr = cnt_q;

endmodule

// File: rtl/vector_register_file.sv
// Multi-lane register file: two registered read ports with write bypass, one
// lane-masked write port, and a zeroing sweep after every reset.
module vector_register_file
   import vrf_pkg::*;
#(
   parameter int NUM_REGS   = 16,
   parameter int NUM_LANES  = 4,
   parameter int LANE_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  enable,
   output logic                                  ready,
   input  logic                                  wr_en,
   input  logic [ADDR_WIDTH-1:0]                 wr_addr,
   input  logic [NUM_LANES-1:0]                  wr_mask,
   input  logic [data_width(NUM_LANES, LANE_WIDTH)-1:0] wr_data,
   input  logic                                  rd_en_a,
   input  logic [ADDR_WIDTH-1:0]                 rd_addr_a,
   output logic [data_width(NUM_LANES, LANE_WIDTH)-1:0] rd_data_a,
   output logic                                  rd_valid_a,
   input  logic                                  rd_en_b,
   input  logic [ADDR_WIDTH-1:0]                 rd_addr_b,
   output logic [data_width(NUM_LANES, LANE_WIDTH)-1:0] rd_data_b,
   output logic                                  rd_valid_b,
   output logic                                  addr_err
);

   localparam int IDX_W = cnt_width(NUM_REGS);

   typedef logic [NUM_LANES-1:0][LANE_WIDTH-1:0] vreg_t;

   function automatic logic is_oob(input logic [ADDR_WIDTH-1:0] a);
      return 32'(a) >= NUM_REGS;
   endfunction

   vreg_t mem_q [NUM_REGS];
   vreg_t mem_d [NUM_REGS];
   vreg_t wr_lanes;

   logic             clr_en;
   logic [IDX_W-1:0] clr_addr;
   logic             wr_acc, wr_ok;
   logic             addr_err_q, addr_err_d;

   logic [1:0]                 rd_en_v;
   logic [1:0][ADDR_WIDTH-1:0] rd_addr_v;

   vrf_clear_fsm #(.NUM_REGS(NUM_REGS), .CNT_W(IDX_W)) u_clear_fsm (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   assign wr_lanes  = wr_data;
   assign wr_acc    = ready && enable && wr_en;
   assign wr_ok     = wr_acc && !is_oob(wr_addr);
   assign rd_en_v   = {rd_en_b, rd_en_a};
   assign rd_addr_v = {rd_addr_b, rd_addr_a};

   // The sweep owns the storage until ready, so user writes never race it.
   always_comb begin
      mem_d = mem_q;
      if (!reset) begin
         if (clr_en) begin
            mem_d[clr_addr] = '0;
         end else if (wr_ok) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               if (wr_mask[i]) mem_d[wr_addr[IDX_W-1:0]][i] = wr_lanes[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      addr_err_d = addr_err_q;
      if (wr_acc && is_oob(wr_addr)) addr_err_d = 1'b1;
      for (int p = 0; p < 2; p++) begin
         if (ready && enable && rd_en_v[p] && is_oob(rd_addr_v[p])) addr_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) addr_err_q <= 1'b0;
      else       addr_err_q <= addr_err_d;
   end

   assign addr_err = addr_err_q;

   for (genvar p = 0; p < 2; p++) begin : gen_rd
      vreg_t data_q, data_d, rd_val;
      logic  valid_q, valid_d;

      // Masked lanes of a same-cycle write to this address win over storage.
      always_comb begin
         rd_val = mem_q[rd_addr_v[p][IDX_W-1:0]];
         if (wr_ok && (wr_addr == rd_addr_v[p])) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               if (wr_mask[i]) rd_val[i] = wr_lanes[i];
            end
         end
         data_d  = data_q;
         valid_d = valid_q;
         if (!ready) begin
            valid_d = 1'b0;
         end else if (enable) begin
            valid_d = rd_en_v[p];
            if (rd_en_v[p]) data_d = is_oob(rd_addr_v[p]) ? '0 : rd_val;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end
   end

   assign rd_data_a  = gen_rd[0].data_q;
   assign rd_valid_a = gen_rd[0].valid_q;
   assign rd_data_b  = gen_rd[1].data_q;
   assign rd_valid_b = gen_rd[1].valid_q;

endmodule

// File: tb/tb_vector_register_file.sv
// Directed bench for vector_register_file with hand-computed expectations.
module tb_vector_register_file;

   logic         clk = 1'b0;
   logic         reset, enable, ready;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [3:0]   wr_mask;
   logic [127:0] wr_data;
   logic         rd_en_a, rd_en_b, rd_valid_a, rd_valid_b, addr_err;
   logic [4:0]   rd_addr_a, rd_addr_b;
   logic [127:0] rd_data_a, rd_data_b;

   int n_run  = 0;
   int n_fail = 0;
   int cyc;
   bit saw_valid;

   localparam logic [127:0] R3_FULL = {32'h44, 32'h33, 32'h22, 32'h11};
   localparam logic [127:0] R3_MRG  = {32'h44, 32'hFFFF_FFFF, 32'h22, 32'hFFFF_FFFF};

   always #5 clk = ~clk;

   vector_register_file dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .ready      (ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_mask    (wr_mask),
      .wr_data    (wr_data),
      .rd_en_a    (rd_en_a),
      .rd_addr_a  (rd_addr_a),
      .rd_data_a  (rd_data_a),
      .rd_valid_a (rd_valid_a),
      .rd_en_b    (rd_en_b),
      .rd_addr_b  (rd_addr_b),
      .rd_data_b  (rd_data_b),
      .rd_valid_b (rd_valid_b),
      .addr_err   (addr_err)
   );

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; rd_en_a = 0; rd_en_b = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      step();
      reset = 0;
   endtask

   // Holds a read request on A throughout the sweep; optionally fires a write
   // to r2 late in the sweep, after r2 has already been cleared.
   task automatic wait_ready(input bit wr_r2, output int n, output bit saw);
      n = 0;
      saw = 0;
      rd_en_a = 1; rd_addr_a = 5'd0;
      while (!ready && n < 100) begin
         if (wr_r2 && n == 10) begin
            wr_en = 1; wr_addr = 5'd2; wr_mask = 4'hF; wr_data = {4{32'h99}};
         end else begin
            wr_en = 0;
         end
         step();
         n++;
         if (!ready) saw |= rd_valid_a;
      end
      idle();
   endtask

   task automatic read_a(input logic [4:0] a);
      idle();
      rd_en_a = 1; rd_addr_a = a;
      step();
      rd_en_a = 0;
   endtask

   initial begin
      reset = 0; enable = 1; wr_en = 0; wr_addr = 0; wr_mask = 0; wr_data = 0;
      rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;

      do_reset();
      chk("rst_ready", ready, 0);
      chk("rst_valid_a", rd_valid_a, 0);
      chk("rst_data_a", rd_data_a, 0);
      chk("rst_valid_b", rd_valid_b, 0);
      chk("rst_addr_err", addr_err, 0);
      wait_ready(0, cyc, saw_valid);
      chk("sweep_len", cyc, 16);
      chk("sweep_no_valid", saw_valid, 0);

      for (int i = 0; i < 16; i++) begin
         rd_en_a = 1; rd_addr_a = 5'(i);
         rd_en_b = 1; rd_addr_b = 5'(15 - i);
         step();
         chk($sformatf("zero_a_r%0d", i), rd_data_a, 0);
         chk($sformatf("zero_vld_a_r%0d", i), rd_valid_a, 1);
         chk($sformatf("zero_b_r%0d", 15 - i), rd_data_b, 0);
      end
      idle();
      step();
      chk("valid_drop_a", rd_valid_a, 0);
      chk("valid_drop_b", rd_valid_b, 0);

      wr_en = 1; wr_addr = 5'd3; wr_mask = 4'hF; wr_data = R3_FULL;
      step();
      read_a(5'd3);
      chk("wr_full_r3", rd_data_a, R3_FULL);
      chk("wr_full_vld", rd_valid_a, 1);

      wr_en = 1; wr_addr = 5'd3; wr_mask = 4'b0101; wr_data = {4{32'hFFFF_FFFF}};
      rd_en_b = 1; rd_addr_b = 5'd3;
      step();
      chk("bypass_merge_b", rd_data_b, R3_MRG);
      chk("bypass_vld_b", rd_valid_b, 1);
      read_a(5'd3);
      chk("merge_stored", rd_data_a, R3_MRG);

      enable = 0;
      wr_en = 1; wr_addr = 5'd5; wr_mask = 4'hF; wr_data = {4{32'hAAAA_AAAA}};
      rd_en_a = 1; rd_addr_a = 5'd0;
      step();
      chk("stall_hold_data", rd_data_a, R3_MRG);
      chk("stall_hold_vld", rd_valid_a, 1);
      enable = 1;
      read_a(5'd5);
      chk("stall_no_write", rd_data_a, 0);

      chk("err_clear_before", addr_err, 0);
      wr_en = 1; wr_addr = 5'd20; wr_mask = 4'hF; wr_data = {4{32'h1234_5678}};
      rd_en_a = 1; rd_addr_a = 5'd20;
      step();
      chk("oob_rd_zero", rd_data_a, 0);
      chk("oob_rd_vld", rd_valid_a, 1);
      chk("oob_err_set", addr_err, 1);
      read_a(5'd4);
      chk("oob_no_alias_r4", rd_data_a, 0);
      read_a(5'd3);
      chk("oob_r3_intact", rd_data_a, R3_MRG);
      chk("err_sticky", addr_err, 1);

      do_reset();
      chk("rst2_err_clear", addr_err, 0);
      for (int i = 0; i < 7; i++) step();
      chk("mid_sweep_not_ready", ready, 0);
      do_reset();
      wait_ready(1, cyc, saw_valid);
      chk("restart_sweep_len", cyc, 16);
      read_a(5'd2);
      chk("clear_wr_lost_r2", rd_data_a, 0);
      read_a(5'd3);
      chk("r3_recleared", rd_data_a, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
